// File: rtl/alu_issue_ctrl_pkg.sv
// alu_ctrl_pkg: FSM states, ALU block/function codes and the PSW update mask.
package alu_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
  localparam logic [1:0] BLK_ARITH = 2'd0;
  localparam logic [1:0] BLK_LOGIC = 2'd1;
  localparam logic [1:0] BLK_SHIFT = 2'd2;
  localparam logic [1:0] BLK_MOVE  = 2'd3;
  localparam logic [1:0] FN_SXT    = 2'd2;
  typedef struct packed {
    logic c;
    logic z;
    logic n;
    logic v;
    logic v_clr;
  } flag_mask_t;
  function automatic flag_mask_t flag_mask(input logic [1:0] sel, input logic [1:0] func);
    return sel == BLK_ARITH ? flag_mask_t'(5'b11110) :
           sel == BLK_LOGIC ? flag_mask_t'(5'b01101) :
           sel == BLK_SHIFT ? (func == FN_SXT ? flag_mask_t'(5'b01100) : flag_mask_t'(5'b11100)) :
           flag_mask_t'(5'b00000);
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: command, register-file, ALU and PSW signals of the issue controller.
interface alu_issue_ctrl_if #(parameter int W = 16);
  logic         cmd_valid, cmd_ready, cmd_byte, cmd_use_const, cmd_no_wb;
  logic [1:0]   cmd_sel, cmd_func;
  logic [2:0]   cmd_dst, cmd_src;
  logic [W-1:0] cmd_const;
  logic [2:0]   rf_raddr_a, rf_raddr_b, rf_waddr;
  logic [W-1:0] rf_rdata_a, rf_rdata_b, rf_wdata;
  logic         rf_we;
  logic [1:0]   block_sel, block_func;
  logic         carry_in, byte_op;
  logic [W-1:0] src_a, src_b, result;
  logic         carry, zero, neg, ovf;
  logic         psw_c, psw_z, psw_n, psw_v, done;
  modport master (
    output cmd_valid, cmd_sel, cmd_func, cmd_byte, cmd_dst, cmd_src, cmd_use_const, cmd_const, cmd_no_wb,
    output rf_rdata_a, rf_rdata_b, result, carry, zero, neg, ovf,
    input  cmd_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    input  block_sel, block_func, carry_in, byte_op, src_a, src_b,
    input  psw_c, psw_z, psw_n, psw_v, done
  );
  modport slave (
    input  cmd_valid, cmd_sel, cmd_func, cmd_byte, cmd_dst, cmd_src, cmd_use_const, cmd_const, cmd_no_wb,
    input  rf_rdata_a, rf_rdata_b, result, carry, zero, neg, ovf,
    output cmd_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
    output block_sel, block_func, carry_in, byte_op, src_a, src_b,
    output psw_c, psw_z, psw_n, psw_v, done
  );
endinterface

// File: rtl/alu_issue_ctrl_psw_reg.sv
// psw_reg: C/Z/N/V flag flops with per-flag load mask and V clear.
module psw_reg
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ld,
  input  flag_mask_t i_mask,
  input  logic       i_c,
  input  logic       i_z,
  input  logic       i_n,
  input  logic       i_v,
  output logic       o_c,
  output logic       o_z,
  output logic       o_n,
  output logic       o_v
);
  logic r_c, r_z, r_n, r_v;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {r_c, r_z, r_n, r_v} <= 4'b0000;
    end else if (i_ld) begin
      r_c <= i_mask.c ? i_c : r_c;
      r_z <= i_mask.z ? i_z : r_z;
      r_n <= i_mask.n ? i_n : r_n;
      r_v <= i_mask.v_clr ? 1'b0 : i_mask.v ? i_v : r_v;
    end
  end
  assign {o_c, o_z, o_n, o_v} = {r_c, r_z, r_n, r_v};
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-cycle IDLE/READ/EXEC/WB sequencer driving the ALU and writing back result and PSW.
module alu_issue_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input logic clk,
  input logic rst_n,
  alu_issue_ctrl_if.slave bus
);
  state_t       r_state, w_next;
  logic [1:0]   r_sel, r_func;
  logic         r_byte, r_use_const, r_no_wb;
  logic [2:0]   r_dst, r_src;
  logic [W-1:0] r_const, r_op_a, r_op_b, r_res;
  logic         r_c, r_z, r_n, r_v;
  logic         w_exec, w_wb, w_psw_c;
  always_ff @(posedge clk) r_state <= !rst_n ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state == S_IDLE ? (bus.cmd_valid ? S_READ : S_IDLE) :
             r_state == S_READ ? S_EXEC :
             r_state == S_EXEC ? S_WB : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.cmd_valid) begin
      {r_sel, r_func, r_byte} <= {bus.cmd_sel, bus.cmd_func, bus.cmd_byte};
      {r_dst, r_src} <= {bus.cmd_dst, bus.cmd_src};
      {r_use_const, r_const, r_no_wb} <= {bus.cmd_use_const, bus.cmd_const, bus.cmd_no_wb};
    end
    if (r_state == S_READ) begin
      r_op_a <= bus.rf_rdata_a;
      r_op_b <= r_use_const ? r_const : bus.rf_rdata_b;
    end
    if (r_state == S_EXEC) begin
      r_res <= bus.result;
      {r_c, r_z, r_n, r_v} <= {bus.carry, bus.zero, bus.neg, bus.ovf};
    end
  end
  // Reset gates the strobes combinationally so an aborted WB never writes.
  always_comb begin
    w_exec         = r_state == S_EXEC && rst_n;
    w_wb           = r_state == S_WB && rst_n;
    bus.cmd_ready  = r_state == S_IDLE;
    bus.rf_raddr_a = r_state == S_IDLE ? bus.cmd_dst : r_dst;
    bus.rf_raddr_b = r_state == S_IDLE ? bus.cmd_src : r_src;
    bus.rf_we      = w_wb && !r_no_wb;
    bus.rf_waddr   = r_dst;
    bus.rf_wdata   = r_byte && r_sel != BLK_MOVE ? {r_op_a[W-1:8], r_res[7:0]} : r_res;
    bus.block_sel  = w_exec ? r_sel : 2'd0;
    bus.block_func = w_exec ? r_func : 2'd0;
    bus.byte_op    = w_exec && r_byte;
    bus.carry_in   = w_exec && w_psw_c;
    bus.src_a      = w_exec ? r_op_a : '0;
    bus.src_b      = w_exec ? r_op_b : '0;
    bus.done       = w_wb;
    bus.psw_c      = w_psw_c;
  end
  psw_reg u_psw (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ld   (w_wb),
    .i_mask (flag_mask(r_sel, r_func)),
    .i_c    (r_c),
    .i_z    (r_z),
    .i_n    (r_n),
    .i_v    (r_v),
    .o_c    (w_psw_c),
    .o_z    (bus.psw_z),
    .o_n    (bus.psw_n),
    .o_v    (bus.psw_v)
  );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed commands against a register-file model and behavioural ALU, scoreboard-checked.
module tb_alu_issue_ctrl;
  import alu_ctrl_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl_if #(.W(16)) bus ();
  alu_issue_ctrl #(.W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [3:0]  psw;
    logic        cin;
    int          acc;
  } exp_t;
  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  logic [15:0] rf [8];
  logic        pk_en = 0;
  logic [2:0]  pk_a0 = 0, pk_a1 = 0;
  logic [15:0] pk_d0 = 0, pk_d1 = 0;
  logic        exec_cin = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: one-cycle read latency, writes from the DUT or bench preload.
  always @(posedge clk) begin
    if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    if (pk_en) begin
      rf[pk_a0] <= pk_d0;
      rf[pk_a1] <= pk_d1;
    end
    bus.rf_rdata_a <= rf[bus.rf_raddr_a];
    bus.rf_rdata_b <= rf[bus.rf_raddr_b];
  end

  // Behavioural ALU. arith: ADD/ADC/SUB/SBC, logic: AND/OR/XOR/NOT, shift: SHL/SHR/SXT/SRA, move: MOV b.
  logic [15:0] bb, r;
  logic [16:0] s17;
  logic [8:0]  s9;
  logic        ci, c, v;
  always_comb begin
    bb  = bus.block_func[1] ? ~bus.src_b : bus.src_b;
    ci  = bus.block_func[0] ? bus.carry_in : bus.block_func[1];
    s9  = {1'b0, bus.src_a[7:0]} + {1'b0, bb[7:0]} + {8'h00, ci};
    s17 = {1'b0, bus.src_a} + {1'b0, bb} + {16'h0000, ci};
    r = 16'h0000;
    c = 1'b0;
    v = 1'b0;
    if (bus.block_sel == BLK_ARITH) begin
      r = bus.byte_op ? {8'h00, s9[7:0]} : s17[15:0];
      c = bus.byte_op ? s9[8] : s17[16];
      v = bus.byte_op ? (bus.src_a[7] == bb[7] && s9[7] != bus.src_a[7])
                      : (bus.src_a[15] == bb[15] && s17[15] != bus.src_a[15]);
    end else if (bus.block_sel == BLK_LOGIC) begin
      r = bus.block_func == 2'd0 ? bus.src_a & bus.src_b :
          bus.block_func == 2'd1 ? bus.src_a | bus.src_b :
          bus.block_func == 2'd2 ? bus.src_a ^ bus.src_b : ~bus.src_a;
    end else if (bus.block_sel == BLK_SHIFT) begin
      r = bus.block_func == 2'd0 ? {bus.src_a[14:0], 1'b0} :
          bus.block_func == 2'd1 ? {1'b0, bus.src_a[15:1]} :
          bus.block_func == 2'd2 ? {{8{bus.src_a[7]}}, bus.src_a[7:0]} : {bus.src_a[15], bus.src_a[15:1]};
      c = bus.block_func == 2'd0 ? bus.src_a[15] : bus.block_func == 2'd2 ? 1'b0 : bus.src_a[0];
    end else begin
      r = bus.src_b;
    end
    bus.result = r;
    bus.carry  = c;
    bus.ovf    = v;
    bus.zero   = bus.byte_op ? r[7:0] == 8'h00 : r == 16'h0000;
    bus.neg    = bus.byte_op ? r[7] : r[15];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.src_a !== 16'h0 || bus.src_b !== 16'h0 || bus.block_sel !== 2'd0 || bus.block_func !== 2'd0)
      exec_cin = bus.carry_in;
    if (bus.done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", {31'd0, bus.done}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc - e.acc, 32'd3);
        chk("rf_we", {31'd0, bus.rf_we}, {31'd0, e.we});
        if (e.we) begin
          chk("rf_waddr", {29'd0, bus.rf_waddr}, {29'd0, e.waddr});
          chk("rf_wdata", {16'd0, bus.rf_wdata}, {16'd0, e.wdata});
        end
        chk("carry_in_at_exec", {31'd0, exec_cin}, {31'd0, e.cin});
        chk("alu_quiet_wb", {31'd0, bus.src_a != 0 || bus.src_b != 0 || bus.block_sel != 0 || bus.carry_in}, 32'd0);
        @(posedge clk);
        #1;
        chk("psw", {28'd0, bus.psw_c, bus.psw_z, bus.psw_n, bus.psw_v}, {28'd0, e.psw});
      end
    end
  end

  task automatic wait_idle;
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: cmd_ready stuck at %b", bus.cmd_ready);
    end
  endtask

  task automatic drive(input logic [1:0] sel, input logic [1:0] func, input logic byt, input logic [2:0] dst,
                       input logic [2:0] src, input logic uc, input logic [15:0] k, input logic nowb);
    bus.cmd_sel = sel;
    bus.cmd_func = func;
    bus.cmd_byte = byt;
    bus.cmd_dst = dst;
    bus.cmd_src = src;
    bus.cmd_use_const = uc;
    bus.cmd_const = k;
    bus.cmd_no_wb = nowb;
    bus.cmd_valid = 1'b1;
  endtask

  task automatic preload(input logic [2:0] a0, input logic [15:0] d0, input logic [2:0] a1, input logic [15:0] d1);
    @(negedge clk);
    wait_idle();
    {pk_a0, pk_d0, pk_a1, pk_d1} = {a0, d0, a1, d1};
    pk_en = 1'b1;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic run(input logic [15:0] va, input logic [15:0] vb, input logic [1:0] sel, input logic [1:0] func,
                     input logic byt, input logic uc, input logic [15:0] k, input logic nowb,
                     input logic [15:0] ewd, input logic [3:0] epsw, input logic ecin);
    preload(3'd0, va, 3'd1, vb);
    drive(sel, func, byt, 3'd0, 3'd1, uc, k, nowb);
    q.push_back('{we: !nowb, waddr: 3'd0, wdata: ewd, psw: epsw, cin: ecin, acc: cyc});
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int busy;
    drive(2'd0, 2'd0, 1'b0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("reset_psw", {28'd0, bus.psw_c, bus.psw_z, bus.psw_n, bus.psw_v}, 32'd0);
    chk("reset_we_done", {30'd0, bus.rf_we, bus.done}, 32'd0);
    chk("reset_alu_quiet", {16'd0, bus.src_a | bus.src_b}, 32'd0);
    //   va       vb       sel        fn    byt   uc    const    nowb  wdata    CZNV     cin
    run(16'h007F, 16'h007F, BLK_ARITH, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h00FE, 4'b0000, 1'b0);
    run(16'h007F, 16'h007F, BLK_ARITH, 2'd2, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b1100, 1'b0);
    run(16'h007F, 16'h007F, BLK_ARITH, 2'd2, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 4'b1100, 1'b1);
    run(16'h007F, 16'h007F, BLK_ARITH, 2'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h00FE, 4'b0011, 1'b1);
    run(16'hFF80, 16'hFF81, BLK_ARITH, 2'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hFF01, 4'b1001, 1'b0);
    run(16'hFF80, 16'hFF81, BLK_ARITH, 2'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'hFF02, 4'b1001, 1'b1);
    run(16'h66AA, 16'h0000, BLK_LOGIC, 2'd0, 1'b0, 1'b1, 16'h99A5, 1'b0, 16'h00A0, 4'b1000, 1'b1);
    run(16'h00A0, 16'h0000, BLK_MOVE,  2'd0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 16'hAAAA, 4'b1000, 1'b1);
    run(16'h0001, 16'h0001, BLK_ARITH, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 4'b0000, 1'b1);
    run(16'h7FFF, 16'h0000, BLK_SHIFT, 2'd3, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h3FFF, 4'b1000, 1'b0);
    run(16'h00AA, 16'h0000, BLK_SHIFT, FN_SXT, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFFAA, 4'b1010, 1'b1);
    run(16'h0000, 16'h0000, BLK_MOVE,  2'd0, 1'b0, 1'b1, 16'h1111, 1'b1, 16'h0000, 4'b1010, 1'b1);
    // cmd_valid held through the busy window with different fields
    preload(3'd2, 16'h1234, 3'd3, 16'h0001);
    drive(BLK_ARITH, 2'd0, 1'b0, 3'd2, 3'd3, 1'b0, 16'h0000, 1'b0);
    q.push_back('{we: 1'b1, waddr: 3'd2, wdata: 16'h1235, psw: 4'b0000, cin: 1'b1, acc: cyc});
    @(posedge clk);
    #1 drive(BLK_MOVE, 2'd0, 1'b0, 3'd4, 3'd4, 1'b1, 16'h5555, 1'b0);
    busy = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && busy < 10) begin
      busy++;
      @(negedge clk);
    end
    chk("busy_cycles", busy, 32'd3);
    q.push_back('{we: 1'b1, waddr: 3'd4, wdata: 16'h5555, psw: 4'b0000, cin: 1'b0, acc: cyc});
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    run(16'h0080, 16'h0000, BLK_SHIFT, FN_SXT, 1'b0, 1'b0, 16'h0000, 1'b0, 16'hFF80, 4'b0010, 1'b0);
    // reset during EXEC aborts the command
    preload(3'd0, 16'hFFFF, 3'd1, 16'h0001);
    drive(BLK_ARITH, 2'd0, 1'b0, 3'd0, 3'd1, 1'b0, 16'h0000, 1'b0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("abort_psw", {28'd0, bus.psw_c, bus.psw_z, bus.psw_n, bus.psw_v}, 32'd0);
    chk("abort_we_done", {30'd0, bus.rf_we, bus.done}, 32'd0);
    repeat (4) @(negedge clk);
    chk("abort_r0_kept", {16'd0, rf[0]}, 32'h0000FFFF);
    run(16'h8000, 16'h8000, BLK_ARITH, 2'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 4'b1101, 1'b0);
    busy = 0;
    while (q.size() != 0 && busy < 50) begin
      @(negedge clk);
      busy++;
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
    $fatal(1, "watchdog timeout");
  end
endmodule
